// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared opcodes, instruction field positions and FSM encoding
package alu_sequencer_pkg;

    localparam int INSTR_W = 8;

    localparam int LDI_BIT = 7;
    localparam int MODE_HI = 6;
    localparam int MODE_LO = 4;
    localparam int RD_HI   = 3;
    localparam int RD_LO   = 2;
    localparam int RS_HI   = 1;
    localparam int RS_LO   = 0;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic is_legal_mode(input logic [2:0] mode);
        return (mode == OP_ADD) || (mode == OP_SUB) || (mode == OP_AND) || (mode == OP_OR);
    endfunction

    // Only arithmetic ops produce a meaningful carry; logic ops leave it stale.
    function automatic logic is_arith(input logic [2:0] mode);
        return (mode == OP_ADD) || (mode == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction offer/accept handshake bundle
interface alu_sequencer_if #(parameter int DATA_W = 8);
    import alu_sequencer_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  imm;

    modport master (output instr_valid, output instr, output imm, input instr_ready);
    modport slave  (input instr_valid, input instr, input imm, output instr_ready);
endinterface

// File: rtl/alu_sequencer_regfile.sv
// rtl/alu_sequencer_regfile.sv - NREG x DATA_W register file, one write port, three read ports
module alu_sequencer_regfile #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [$clog2(NREG)-1:0]   waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [$clog2(NREG)-1:0]   raddr_a,
    output logic [DATA_W-1:0]         rdata_a,
    input  logic [$clog2(NREG)-1:0]   raddr_b,
    output logic [DATA_W-1:0]         rdata_b,
    input  logic [$clog2(NREG)-1:0]   raddr_dbg,
    output logic [DATA_W-1:0]         rdata_dbg
);
    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a   = regs[raddr_a];
    assign rdata_b   = regs[raddr_b];
    assign rdata_dbg = regs[raddr_dbg];
endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issues one instruction at a time to an external registered ALU
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_sequencer_if.slave          bus,
    output logic                    alu_enable,
    output logic [2:0]              alu_mode,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    input  logic [DATA_W-1:0]       alu_out,
    input  logic                    alu_zero,
    input  logic                    alu_carry,
    input  logic [$clog2(NREG)-1:0] rd_sel,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    zero_q,
    output logic                    carry_q,
    output logic                    done,
    output logic                    err
);
    localparam int AW = $clog2(NREG);

    state_t            state, state_nxt;
    logic              fire, fire_ldi, fire_alu, fire_bad;
    logic              is_ldi, legal;
    logic [2:0]        mode_in;
    logic [AW-1:0]     rd_in, rs_in, rd_q;
    logic              ldi_done_q;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata, op_a, op_b;

    assign is_ldi   = bus.instr[LDI_BIT];
    assign mode_in  = bus.instr[MODE_HI:MODE_LO];
    assign rd_in    = bus.instr[RD_HI:RD_LO];
    assign rs_in    = bus.instr[RS_HI:RS_LO];
    assign legal    = is_legal_mode(mode_in);

    assign bus.instr_ready = (state == ST_IDLE);
    assign fire     = bus.instr_valid & bus.instr_ready;
    assign fire_ldi = fire & is_ldi;
    assign fire_alu = fire & ~is_ldi & legal;
    assign fire_bad = fire & ~is_ldi & ~legal;

    // WB and an IDLE accept are mutually exclusive, so one write port suffices.
    assign rf_we    = fire_ldi | (state == ST_WB);
    assign rf_waddr = (state == ST_WB) ? rd_q : rd_in;
    assign rf_wdata = (state == ST_WB) ? alu_out : bus.imm;

    alu_sequencer_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata),
        .raddr_a   (rd_in),
        .rdata_a   (op_a),
        .raddr_b   (rs_in),
        .rdata_b   (op_b),
        .raddr_dbg (rd_sel),
        .rdata_dbg (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = ldi_done_q;
        case (state)
            ST_IDLE: if (fire_alu) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB: begin
                state_nxt = ST_IDLE;
                done      = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operands are captured at accept so they are stable for the whole EXEC cycle and held afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_enable <= 1'b0;
            alu_mode   <= 3'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            rd_q       <= '0;
            ldi_done_q <= 1'b0;
            err        <= 1'b0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            alu_enable <= fire_alu;
            ldi_done_q <= fire_ldi;
            err        <= fire_bad;
            if (fire_alu) begin
                alu_mode <= mode_in;
                alu_a    <= op_a;
                alu_b    <= op_b;
                rd_q     <= rd_in;
            end
            if (state == ST_WB) begin
                zero_q <= alu_zero;
                if (is_arith(alu_mode)) begin
                    carry_q <= alu_carry;
                end
            end
        end
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: DATA_W, 8, datapath width; SHALL match the 8-bit ALU operand width.
REQ-002 Parameter: NREG, 4, register count; register index width SHALL be 2.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 instr_valid  in  1  instruction offered.
REQ-006 instr_ready  out  1  sequencer accepts instruction this cycle.
REQ-007 instr  in  8  [7]=ldi, [6:4]=ALU mode, [3:2]=rd (also operand A), [1:0]=rs (operand B).
REQ-008 imm  in  8  immediate for ldi, sampled with instr.
REQ-009 alu_enable  out  1  drives ALU enable.
REQ-010 alu_mode  out  3  drives ALU mode.
REQ-011 alu_a, alu_b  out  8 each  drive ALU operands.
REQ-012 alu_out  in  8  ALU result (registered inside ALU).
REQ-013 alu_zero, alu_carry  in  1 each  ALU flags.
REQ-014 rd_sel  in  2  debug read-port index; rd_data  out  8  regs[rd_sel], combinational.
REQ-015 zero_q, carry_q  out  1 each  architectural flags.
REQ-016 done  out  1  one-cycle pulse on instruction retire; err  out  1  one-cycle pulse on illegal mode.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, WB.
REQ-018 instr_ready SHALL be 1 only in IDLE; handshake = instr_valid & instr_ready.
REQ-019 ldi accepted in IDLE: regs[rd] <= imm at that edge; flags unchanged; done=1 next cycle; stays IDLE (1-cycle throughput).
REQ-020 ALU instruction with legal mode (OP_ADD, OP_SUB, OP_AND, OP_OR) accepted in IDLE: latch rd, rs, mode; go to EXEC.
REQ-021 EXEC: alu_enable=1 for exactly one cycle; alu_a=regs[rd], alu_b=regs[rs], alu_mode=latched mode; next state WB.
REQ-022 WB: alu_out and flags are valid; at end of WB regs[rd] <= alu_out, zero_q <= alu_zero; done=1 during WB; next state IDLE.
REQ-023 carry_q SHALL update in WB only for OP_ADD/OP_SUB; OP_AND/OP_OR SHALL leave carry_q unchanged (ALU carry is stale for these).
REQ-024 Illegal mode (non-ldi, not one of the four): no register/flag write, err=1 next cycle, stays IDLE.
REQ-025 Outside EXEC: alu_enable=0; alu_a, alu_b, alu_mode SHALL hold last driven values.
REQ-026 Latency: ALU op accept-to-writeback = 3 cycles; max one instruction in flight.
REQ-027 rd == rs SHALL be legal (e.g. r1 = r1 + r1).
REQ-028 instr_valid asserted outside IDLE SHALL be ignored and not consumed.
REQ-029 rd_data SHALL reflect a WB/ldi write on the cycle after the write edge.

Reset
REQ-030 rst_n=0 at a posedge: state=IDLE, all regs=0, zero_q=0, carry_q=0, alu_enable=0, alu_a=alu_b=0, alu_mode=0, done=0, err=0.
REQ-031 Reset in EXEC or WB SHALL abort the instruction with no writeback; ALU internal state is not reset and SHALL NOT be relied on.

Structure
REQ-032 OP_* mode codes SHALL come from the shared parameters.v; state encodings and the instr field positions SHALL be added there.
REQ-033 Register file (NREG x DATA_W, one write port, two operand read ports plus debug port) SHALL be sub-module regfile; sequencer instantiates it and the existing alu in its top-level test wrapper.

Verification
REQ-034 Reset, then ldi r0=0x05, ldi r1=0x03 -> rd_data(r0)=0x05, rd_data(r1)=0x03, done each cycle.
REQ-035 ADD r0,r1 (0x05+0x03) -> alu_enable high 1 cycle, done 3 cycles after accept, r0=0x08, zero_q=0, carry_q=0.
REQ-036 ldi r2=0xFF, ldi r3=0x01, ADD r2,r3 -> r2=0x00, zero_q=1, carry_q=1; then AND r2,r3 -> r2=0x00, zero_q=1, carry_q stays 1.
REQ-037 SUB r0,r0 with r0=0x08 -> r0=0x00, zero_q=1, carry_q=0.
REQ-038 Illegal mode instr -> err pulse, regs and flags unchanged, instr_ready=1 next cycle.
REQ-039 rst_n low during EXEC of ADD -> state IDLE, all regs 0, no done pulse.
